// File: rtl/dust_alarm_pkg.sv
// Shared defaults, hysteresis state encoding and marker helper for the zoned dust alarm.
package dust_alarm_pkg;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_ZONES      = 4;
  localparam int DEF_IDX_W      = 10;
  localparam int DEF_HYST_SCANS = 3;

  typedef enum logic {
    HYST_CLEAN = 1'b0,
    HYST_ALARM = 1'b1
  } hyst_state_e;

  // All-ones dust marker for widths up to 64; callers truncate to their width.
  function automatic logic [63:0] dust_marker(input int unsigned width);
    dust_marker = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction
endpackage

// File: rtl/dust_alarm_zoned_if.sv
// Distance sample stream in from the distance calculator and marked stream out to the scan packer.
interface dust_alarm_zoned_if
  import dust_alarm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              zero_flag;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_out_valid;
  logic [DATA_W-1:0] data_out;

  modport master (
    output zero_flag, data_in_valid, data_in,
    input  data_out_valid, data_out
  );

  modport slave (
    input  zero_flag, data_in_valid, data_in,
    output data_out_valid, data_out
  );
endinterface

// File: rtl/dust_zone_hyst.sv
// Per-zone alarm with scan-level hysteresis, evaluated once per scan snapshot.
//   state      | meaning
//   HYST_CLEAN | alarm low; run counts consecutive dirty scans
//   HYST_ALARM | alarm high; run counts consecutive clean scans
module dust_zone_hyst
  import dust_alarm_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HYST_SCANS = DEF_HYST_SCANS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snap,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] alarm_limit,
  output logic             alarm
);
  localparam int RUN_W = $clog2(HYST_SCANS + 1);

  hyst_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             dirty;

  assign run_inc = run_q + 1'b1;
  assign dirty   = (count > alarm_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HYST_CLEAN;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (snap) begin
      case (state_q)
        HYST_CLEAN: begin
          if (!dirty) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(HYST_SCANS)) begin
            state_d = HYST_ALARM;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        HYST_ALARM: begin
          if (dirty) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(HYST_SCANS)) begin
            state_d = HYST_CLEAN;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = HYST_CLEAN;
          run_d   = '0;
        end
      endcase
    end
  end

  assign alarm = (state_q == HYST_ALARM);
endmodule

// File: rtl/dust_alarm_zoned.sv
// Marks near-window dust returns, counts them per angular zone each scan,
// and drives a hysteretic alarm per zone.
module dust_alarm_zoned
  import dust_alarm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ZONES      = DEF_ZONES,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int HYST_SCANS = DEF_HYST_SCANS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      dust_threshold,
  input  logic [CNT_W-1:0]       alarm_limit,
  input  logic [IDX_W-1:0]       zone_len,
  dust_alarm_zoned_if.slave      stream,
  output logic [ZONES*CNT_W-1:0] zone_cnt,
  output logic                   cnt_valid,
  output logic [ZONES-1:0]       dust_alarm
);
  localparam int ZI_W = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam logic [DATA_W-1:0] MARK = DATA_W'(dust_marker(DATA_W));

  logic [IDX_W-1:0] pt_cnt, pt_nxt, base_pt, eff_len;
  logic [ZI_W-1:0]  zone_idx, zi_nxt, base_zi;
  logic [CNT_W-1:0] acc     [ZONES];
  logic [CNT_W-1:0] acc_nxt [ZONES];
  logic             hit;

  assign hit = (dust_threshold != '0) && stream.data_in_valid &&
               (stream.data_in <= dust_threshold);
  assign eff_len = (zone_len == '0) ? IDX_W'(1) : zone_len;

  // A sample coinciding with zero_flag is the first sample of the new scan,
  // so the advance/accumulate step always starts from the post-close base.
  always_comb begin
    base_pt = stream.zero_flag ? '0 : pt_cnt;
    base_zi = stream.zero_flag ? '0 : zone_idx;
    for (int k = 0; k < ZONES; k++) begin
      acc_nxt[k] = stream.zero_flag ? '0 : acc[k];
    end
    pt_nxt = base_pt;
    zi_nxt = base_zi;
    if (stream.data_in_valid) begin
      if ((base_pt == eff_len - 1'b1) && (base_zi < ZI_W'(ZONES - 1))) begin
        pt_nxt = '0;
        zi_nxt = base_zi + 1'b1;
      end else if (base_pt != '1) begin
        pt_nxt = base_pt + 1'b1;
      end
      if (hit && (acc_nxt[base_zi] != '1)) begin
        acc_nxt[base_zi] = acc_nxt[base_zi] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_cnt                <= '0;
      zone_idx              <= '0;
      stream.data_out       <= '0;
      stream.data_out_valid <= 1'b0;
      zone_cnt              <= '0;
      cnt_valid             <= 1'b0;
      for (int k = 0; k < ZONES; k++) begin
        acc[k] <= '0;
      end
    end else begin
      pt_cnt                <= pt_nxt;
      zone_idx              <= zi_nxt;
      stream.data_out_valid <= stream.data_in_valid;
      cnt_valid             <= stream.zero_flag;
      if (stream.data_in_valid) begin
        stream.data_out <= hit ? MARK : stream.data_in;
      end
      for (int k = 0; k < ZONES; k++) begin
        acc[k] <= acc_nxt[k];
        if (stream.zero_flag) begin
          zone_cnt[k*CNT_W +: CNT_W] <= acc[k];
        end
      end
    end
  end

  // Hysteresis sees the count being snapshotted so the alarm moves with cnt_valid.
  for (genvar k = 0; k < ZONES; k++) begin : g_zone
    dust_zone_hyst #(
      .CNT_W      (CNT_W),
      .HYST_SCANS (HYST_SCANS)
    ) u_hyst (
      .clk         (clk),
      .rst_n       (rst_n),
      .snap        (stream.zero_flag),
      .count       (acc[k]),
      .alarm_limit (alarm_limit),
      .alarm       (dust_alarm[k])
    );
  end
endmodule

// File: tb/tb_dust_alarm_zoned.sv
// Directed bench for dust_alarm_zoned with a narrow counter so saturation is reachable.
module tb_dust_alarm_zoned;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int ZONES  = 4;
  localparam int IDX_W  = 10;
  localparam int HYST   = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DATA_W-1:0]      dust_threshold;
  logic [CNT_W-1:0]       alarm_limit;
  logic [IDX_W-1:0]       zone_len;
  logic [ZONES*CNT_W-1:0] zone_cnt;
  logic                   cnt_valid;
  logic [ZONES-1:0]       dust_alarm;

  int tests_run = 0;
  int tests_failed = 0;

  dust_alarm_zoned_if #(.DATA_W(DATA_W)) bus ();

  dust_alarm_zoned #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ZONES(ZONES), .IDX_W(IDX_W), .HYST_SCANS(HYST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dust_threshold (dust_threshold),
    .alarm_limit    (alarm_limit),
    .zone_len       (zone_len),
    .stream         (bus),
    .zone_cnt       (zone_cnt),
    .cnt_valid      (cnt_valid),
    .dust_alarm     (dust_alarm)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic zf, input logic v, input logic [DATA_W-1:0] d);
    bus.zero_flag     = zf;
    bus.data_in_valid = v;
    bus.data_in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hits(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 16'd10);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.data_out_valid, bus.data_out, zone_cnt, cnt_valid, dust_alarm} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got dov=%b do=%h zc=%h cv=%b al=%b required all 0",
               bus.data_out_valid, bus.data_out, zone_cnt, cnt_valid, dust_alarm);
    end
  endtask

  task automatic test_marking();
    logic [DATA_W-1:0] samp [4];
    logic [DATA_W-1:0] expv [4];
    samp = '{16'd50, 16'd100, 16'd101, 16'd0};
    expv = '{16'hFFFF, 16'hFFFF, 16'd101, 16'hFFFF};
    dust_threshold = 16'd100;
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, samp[i]);
      tests_run++;
      if (bus.data_out !== expv[i] || bus.data_out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL mark_%0d: got do=%h dov=%b required do=%h dov=1", i, bus.data_out,
                 bus.data_out_valid, expv[i]);
      end
    end
    drive(1'b0, 1'b0, 16'h1234);
    tests_run++;
    if (bus.data_out !== 16'hFFFF || bus.data_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mark_hold: got do=%h dov=%b required do=ffff dov=0", bus.data_out,
               bus.data_out_valid);
    end
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h0003 || cnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mark_count: got zc=%h cv=%b required zc=0003 cv=1", zone_cnt, cnt_valid);
    end
    drive(1'b0, 1'b0, '0);
    tests_run++;
    if (cnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mark_cv_pulse: got cv=%b required 0", cnt_valid);
    end
    dust_threshold = 16'd0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, samp[i]);
      tests_run++;
      if (bus.data_out !== samp[i]) begin
        tests_failed++;
        $display("FAIL pass_%0d: got do=%h required %h", i, bus.data_out, samp[i]);
      end
    end
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h0000 || cnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_count: got zc=%h cv=%b required zc=0000 cv=1", zone_cnt, cnt_valid);
    end
  endtask

  task automatic test_zoning();
    logic is_hit;
    dust_threshold = 16'd100;
    zone_len       = 10'd5;
    for (int i = 0; i < 25; i++) begin
      is_hit = (i == 0) || (i == 4) || (i == 5) || (i == 19) || (i == 20) || (i == 24);
      drive(1'b0, 1'b1, is_hit ? 16'd10 : 16'd500);
    end
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h3012 || cnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL zoning: got zc=%h cv=%b required zc=3012 cv=1", zone_cnt, cnt_valid);
    end
    drive(1'b0, 1'b0, '0);
    tests_run++;
    if (cnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zoning_cv_pulse: got cv=%b required 0", cnt_valid);
    end
    zone_len = 10'd0;
    send_hits(6);
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h3111) begin
      tests_failed++;
      $display("FAIL zone_len_zero: got zc=%h required 3111", zone_cnt);
    end
  endtask

  task automatic test_saturation();
    zone_len = 10'd100;
    send_hits(20);
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h000F) begin
      tests_failed++;
      $display("FAIL saturation: got zc=%h required 000f", zone_cnt);
    end
  endtask

  task automatic test_coincidence();
    zone_len = 10'd5;
    send_hits(2);
    drive(1'b1, 1'b1, 16'd10);
    tests_run++;
    if (zone_cnt !== 16'h0002 || cnt_valid !== 1'b1 || bus.data_out !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL coinc_snap: got zc=%h cv=%b do=%h required zc=0002 cv=1 do=ffff",
               zone_cnt, cnt_valid, bus.data_out);
    end
    send_hits(1);
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h0002) begin
      tests_failed++;
      $display("FAIL coinc_next: got zc=%h required 0002", zone_cnt);
    end
  endtask

  task automatic test_back_to_back();
    send_hits(3);
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h0000 || cnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL back_to_back: got zc=%h cv=%b required zc=0000 cv=1", zone_cnt, cnt_valid);
    end
  endtask

  task automatic test_hysteresis();
    int   cnts [12];
    logic expa [12];
    cnts = '{5, 5, 1, 5, 5, 5, 0, 0, 9, 0, 0, 0};
    expa = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    alarm_limit = 4'd2;
    zone_len    = 10'd100;
    for (int i = 0; i < 12; i++) begin
      send_hits(cnts[i]);
      drive(1'b1, 1'b0, '0);
      tests_run++;
      if (dust_alarm !== {3'b000, expa[i]} || zone_cnt !== {12'h000, 4'(cnts[i])}) begin
        tests_failed++;
        $display("FAIL hyst_%0d: got al=%b zc=%h required al=%b zc=%h", i, dust_alarm,
                 zone_cnt, {3'b000, expa[i]}, {12'h000, 4'(cnts[i])});
      end
    end
    alarm_limit = 4'd15;
  endtask

  task automatic test_reset_mid_scan();
    zone_len = 10'd5;
    send_hits(3);
    drive(1'b1, 1'b0, '0);
    send_hits(7);
    #2 rst_n = 1'b0;
    bus.data_in_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.data_out_valid, bus.data_out, zone_cnt, cnt_valid, dust_alarm} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got dov=%b do=%h zc=%h cv=%b al=%b required all 0",
               bus.data_out_valid, bus.data_out, zone_cnt, cnt_valid, dust_alarm);
    end
    #3 rst_n = 1'b1;
    send_hits(2);
    drive(1'b1, 1'b0, '0);
    tests_run++;
    if (zone_cnt !== 16'h0002 || cnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_next_scan: got zc=%h cv=%b required zc=0002 cv=1", zone_cnt,
               cnt_valid);
    end
  endtask

  initial begin
    bus.zero_flag     = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    dust_threshold    = 16'd100;
    alarm_limit       = 4'd15;
    zone_len          = 10'd5;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_marking();
    test_zoning();
    test_saturation();
    test_coincidence();
    test_back_to_back();
    test_hysteresis();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
